// File: rtl/tm1637_pkg.sv
// Shared types and constants for the TM1637 bus responder.
package tm1637_pkg;

  // Protocol FSM states; the encoding is exported on debug_state
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Command class, taken from bits [7:6] of the first byte after START
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_ADDR = 2'b11;
  localparam logic [1:0] CMD_CTRL = 2'b10;

  // Flag bit positions inside command bytes
  localparam int BIT_FIXED_ADDR = 2;
  localparam int BIT_KEY_READ   = 1;
  localparam int BIT_DISP_ON    = 3;

  // Idle bus levels; both lines are pulled up
  localparam logic CLK_IDLE = 1'b1;
  localparam logic DIO_IDLE = 1'b1;

  // Auto-increment address step, wrapping at the last digit
  function automatic logic [2:0] next_addr(input logic [2:0] a, input int num);
    if (int'(a) == num - 1) return 3'd0;
    return a + 3'd1;
  endfunction

endpackage

// File: rtl/tm1637_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous bus line.
module tm1637_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw line through the chain; keep last synchronized value for edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{IDLE_LVL}};
      prev_q <= IDLE_LVL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Edges are formed only from flopped values, so they are glitch-free
  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/tm1637_responder.sv
// TM1637 display-controller bus responder: decodes data, address and
// display-control commands and holds the resulting display RAM.
module tm1637_responder
  import tm1637_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DIGITS  = 6
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic                    tm1637_clk,
  input  logic                    tm1637_dio_in,
  output logic                    tm1637_dio_oe,
  output logic [8*NUM_DIGITS-1:0] seg_data,
  output logic                    disp_on,
  output logic [2:0]              brightness,
  output logic                    update_strobe,
  output logic                    proto_err,
  output logic [2:0]              debug_state
);

  logic clk_lvl, clk_rise, clk_fall;
  logic dio_lvl, dio_rise, dio_fall;

  tm1637_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(CLK_IDLE)) u_sync_clk (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .din   (tm1637_clk),
    .level (clk_lvl),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  tm1637_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(DIO_IDLE)) u_sync_dio (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .din   (tm1637_dio_in),
    .level (dio_lvl),
    .rise  (dio_rise),
    .fall  (dio_fall)
  );

  // A DIO change coinciding with a CLK edge is taken as the CLK edge only
  logic clk_edge, bus_start, bus_stop;
  assign clk_edge  = clk_rise | clk_fall;
  assign bus_start = dio_fall & clk_lvl & ~clk_edge;
  assign bus_stop  = dio_rise & clk_lvl & ~clk_edge;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;      // bits 0..6 of the byte in flight, LSB first
  logic       byte_full;  // 8th bit sampled, waiting for the 8th falling edge
  logic       ack_ok;     // the completed byte is to be acknowledged
  logic       first_byte; // next completed byte is the command byte
  logic       wr_active;  // valid address command seen: data bytes write RAM
  logic       discard;    // bad address command seen: data bytes dropped
  logic       mode_fixed; // 1 = fixed address, 0 = auto-increment
  logic       dirty;      // something was updated since the last STOP
  logic [2:0] addr;
  logic [7:0] rx_byte;

  assign rx_byte     = {dio_lvl, shreg};
  assign debug_state = state;

  // Protocol FSM, byte decode and register file
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tm1637_dio_oe <= 1'b0;
      seg_data      <= '0;
      disp_on       <= 1'b0;
      brightness    <= 3'd0;
      update_strobe <= 1'b0;
      proto_err     <= 1'b0;
      bit_cnt       <= 3'd0;
      shreg         <= 7'd0;
      byte_full     <= 1'b0;
      ack_ok        <= 1'b0;
      first_byte    <= 1'b0;
      wr_active     <= 1'b0;
      discard       <= 1'b0;
      mode_fixed    <= 1'b0;
      dirty         <= 1'b0;
      addr          <= 3'd0;
    end else begin
      update_strobe <= 1'b0;
      if (bus_stop) begin
        state         <= ST_IDLE;
        tm1637_dio_oe <= 1'b0;
        update_strobe <= dirty;
        dirty         <= 1'b0;
        bit_cnt       <= 3'd0;
        byte_full     <= 1'b0;
        wr_active     <= 1'b0;
        discard       <= 1'b0;
      end else if (bus_start) begin
        // A partial byte is abandoned; only a started byte counts as an error
        if ((state == ST_BIT || state == ST_ACK || state == ST_HOLD) && bit_cnt != 3'd0)
          proto_err <= 1'b1;
        state         <= ST_START;
        tm1637_dio_oe <= 1'b0;
        bit_cnt       <= 3'd0;
        byte_full     <= 1'b0;
        first_byte    <= 1'b1;
        wr_active     <= 1'b0;
        discard       <= 1'b0;
      end else begin
        case (state)
          ST_START: if (clk_fall) state <= ST_BIT;

          ST_BIT: begin
            if (clk_rise && !byte_full) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt != 3'd7) begin
                shreg <= {dio_lvl, shreg[6:1]};
              end else begin
                byte_full <= 1'b1;
                ack_ok    <= 1'b1;
                if (first_byte) begin
                  first_byte <= 1'b0;
                  case (rx_byte[7:6])
                    CMD_DATA: begin
                      if (rx_byte[BIT_KEY_READ]) begin
                        proto_err <= 1'b1;
                        ack_ok    <= 1'b0;
                      end else begin
                        mode_fixed <= rx_byte[BIT_FIXED_ADDR];
                        dirty      <= 1'b1;
                      end
                    end
                    CMD_ADDR: begin
                      if (int'(rx_byte[2:0]) >= NUM_DIGITS) begin
                        proto_err <= 1'b1;
                        discard   <= 1'b1;
                      end else begin
                        addr      <= rx_byte[2:0];
                        wr_active <= 1'b1;
                        dirty     <= 1'b1;
                      end
                    end
                    CMD_CTRL: begin
                      disp_on    <= rx_byte[BIT_DISP_ON];
                      brightness <= rx_byte[2:0];
                      dirty      <= 1'b1;
                    end
                    default: proto_err <= 1'b1;
                  endcase
                end else if (wr_active) begin
                  for (int i = 0; i < NUM_DIGITS; i++)
                    if (int'(addr) == i) seg_data[8*i +: 8] <= rx_byte;
                  if (!mode_fixed) addr <= next_addr(addr, NUM_DIGITS);
                  dirty <= 1'b1;
                end else if (!discard) begin
                  // trailing byte after a data or display-control command
                  proto_err <= 1'b1;
                end
              end
            end else if (clk_fall && byte_full) begin
              byte_full <= 1'b0;
              if (ack_ok) begin
                state         <= ST_ACK;
                tm1637_dio_oe <= 1'b1;
              end else begin
                state <= ST_HOLD;
              end
            end
          end

          // The counter is already 0 here, so the next byte starts cleanly
          ST_ACK: begin
            if (clk_fall) begin
              tm1637_dio_oe <= 1'b0;
              state         <= ST_BIT;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tm1637_responder.sv
// Directed bench for tm1637_responder: bit-banged TM1637 master with open-drain DIO.
module tb_tm1637_responder;

  localparam int H = 8;  // bus half period in system clocks
  localparam int Q = 4;  // setup gap between DIO change and CLK edge

  logic        clk_50M = 1'b0;
  logic        rst_n   = 1'b0;
  logic        bus_clk = 1'b1;
  logic        dio_m   = 1'b1;
  logic        tm1637_dio_in;
  logic        tm1637_dio_oe;
  logic [47:0] seg_data;
  logic        disp_on;
  logic [2:0]  brightness;
  logic        update_strobe;
  logic        proto_err;
  logic [2:0]  debug_state;

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int ack_cnt    = 0;
  logic oe_q = 1'b0;

  assign tm1637_dio_in = dio_m & ~tm1637_dio_oe;

  tm1637_responder #(.SYNC_STAGES(2), .NUM_DIGITS(6)) dut (
    .clk_50M       (clk_50M),
    .rst_n         (rst_n),
    .tm1637_clk    (bus_clk),
    .tm1637_dio_in (tm1637_dio_in),
    .tm1637_dio_oe (tm1637_dio_oe),
    .seg_data      (seg_data),
    .disp_on       (disp_on),
    .brightness    (brightness),
    .update_strobe (update_strobe),
    .proto_err     (proto_err),
    .debug_state   (debug_state)
  );

  always #10 clk_50M = ~clk_50M;

  // Count strobe cycles and ACK pulses (rising edges of dio_oe)
  always @(posedge clk_50M) begin
    if (update_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (tm1637_dio_oe === 1'b1 && oe_q !== 1'b1) ack_cnt <= ack_cnt + 1;
    oe_q <= tm1637_dio_oe;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic do_reset();
    bus_clk = 1'b1; dio_m = 1'b1;
    rst_n = 1'b0; cyc(3);
    rst_n = 1'b1; cyc(2);
  endtask

  task automatic bus_start();
    bus_clk = 1'b1; dio_m = 1'b1; cyc(H);
    dio_m = 1'b0; cyc(H);
    bus_clk = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop();
    dio_m = 1'b0; cyc(Q);
    bus_clk = 1'b1; cyc(H);
    dio_m = 1'b1; cyc(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      dio_m = b[i]; cyc(Q);
      bus_clk = 1'b1; cyc(H);
      bus_clk = 1'b0; cyc(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    dio_m = 1'b1; cyc(Q);
    bus_clk = 1'b1; cyc(H/2);
    ack = tm1637_dio_oe;
    cyc(H/2);
    bus_clk = 1'b0; cyc(Q);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_clk = 1'b1; dio_m = 1'b1;
    cyc(4);
    checks++; if (seg_data !== 48'h0) begin failures++; $display("FAIL reset_seg got=%h exp=0", seg_data); end
    checks++; if (disp_on !== 1'b0) begin failures++; $display("FAIL reset_disp_on got=%b exp=0", disp_on); end
    checks++; if (brightness !== 3'd0) begin failures++; $display("FAIL reset_brightness got=%0d exp=0", brightness); end
    checks++; if (update_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", update_strobe); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    checks++; if (tm1637_dio_oe !== 1'b0) begin failures++; $display("FAIL reset_dio_oe got=%b exp=0", tm1637_dio_oe); end
    checks++; if (debug_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", debug_state); end
    rst_n = 1'b1; cyc(2);
  endtask

  task automatic test_data_write();
    int s0, a0;
    logic ack;
    s0 = strobe_cnt;
    bus_start(); send_byte(8'h40, ack); bus_stop();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL datacmd_ack got=%b exp=1", ack); end
    checks++; if (strobe_cnt !== s0 + 1) begin failures++; $display("FAIL datacmd_strobe got=%0d exp=%0d", strobe_cnt, s0 + 1); end
    a0 = ack_cnt;
    bus_start();
    send_byte(8'hC0, ack); send_byte(8'h3F, ack); send_byte(8'h06, ack); send_byte(8'h5B, ack);
    bus_stop();
    checks++; if (ack_cnt !== a0 + 4) begin failures++; $display("FAIL write_acks got=%0d exp=%0d", ack_cnt - a0, 4); end
    checks++; if (seg_data !== 48'h00_00_00_5B_06_3F) begin failures++; $display("FAIL write_seg got=%h exp=%h", seg_data, 48'h00005B063F); end
    checks++; if (strobe_cnt !== s0 + 2) begin failures++; $display("FAIL write_strobe got=%0d exp=%0d", strobe_cnt, s0 + 2); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL write_proto_err got=%b exp=0", proto_err); end
    checks++; if (debug_state !== 3'd0) begin failures++; $display("FAIL write_idle got=%0d exp=0", debug_state); end
  endtask

  task automatic test_display_ctrl();
    int s0;
    logic ack;
    s0 = strobe_cnt;
    bus_start(); send_byte(8'h8F, ack); bus_stop();
    checks++; if (disp_on !== 1'b1) begin failures++; $display("FAIL ctrl_disp_on got=%b exp=1", disp_on); end
    checks++; if (brightness !== 3'd7) begin failures++; $display("FAIL ctrl_brightness got=%0d exp=7", brightness); end
    checks++; if (strobe_cnt !== s0 + 1) begin failures++; $display("FAIL ctrl_strobe got=%0d exp=%0d", strobe_cnt, s0 + 1); end
    checks++; if (seg_data !== 48'h00005B063F) begin failures++; $display("FAIL ctrl_seg got=%h exp=%h", seg_data, 48'h00005B063F); end
  endtask

  task automatic test_fixed_addr();
    int s0;
    logic ack;
    s0 = strobe_cnt;
    bus_start(); send_byte(8'h44, ack); bus_stop();
    bus_start(); send_byte(8'hC5, ack); send_byte(8'h11, ack); send_byte(8'h22, ack); bus_stop();
    checks++; if (seg_data !== 48'h22_00_00_5B_06_3F) begin failures++; $display("FAIL fixed_seg got=%h exp=%h", seg_data, 48'h2200005B063F); end
    checks++; if (strobe_cnt !== s0 + 2) begin failures++; $display("FAIL fixed_strobe got=%0d exp=%0d", strobe_cnt, s0 + 2); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL fixed_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_auto_wrap();
    logic ack;
    bus_start(); send_byte(8'h40, ack); bus_stop();
    bus_start(); send_byte(8'hC4, ack);
    send_byte(8'hA1, ack); send_byte(8'hA2, ack); send_byte(8'hA3, ack); send_byte(8'hA4, ack);
    bus_stop();
    checks++; if (seg_data !== 48'hA2_A1_00_5B_A4_A3) begin failures++; $display("FAIL wrap_seg got=%h exp=%h", seg_data, 48'hA2A1005BA4A3); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL wrap_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_errors();
    int s0;
    logic ack;
    // key-read data command: no ACK, sticky error, nothing updated
    do_reset();
    s0 = strobe_cnt;
    bus_start(); send_byte(8'h42, ack); bus_stop();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL keyread_ack got=%b exp=0", ack); end
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL keyread_proto_err got=%b exp=1", proto_err); end
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL keyread_strobe got=%0d exp=%0d", strobe_cnt, s0); end
    // class 00 command byte
    do_reset();
    s0 = strobe_cnt;
    bus_start(); send_byte(8'h00, ack); bus_stop();
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL cls00_proto_err got=%b exp=1", proto_err); end
    checks++; if (seg_data !== 48'h0 || disp_on !== 1'b0) begin failures++; $display("FAIL cls00_regs got=%h/%b exp=0/0", seg_data, disp_on); end
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL cls00_strobe got=%0d exp=%0d", strobe_cnt, s0); end
    // repeated START after 3 bits of a byte
    do_reset();
    s0 = strobe_cnt;
    bus_start(); send_bits(8'h40, 3);
    dio_m = 1'b1; cyc(Q);
    bus_clk = 1'b1; cyc(H);
    dio_m = 1'b0; cyc(H);
    bus_clk = 1'b0; cyc(Q);
    bus_stop();
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL midstart_proto_err got=%b exp=1", proto_err); end
    checks++; if (seg_data !== 48'h0) begin failures++; $display("FAIL midstart_seg got=%h exp=0", seg_data); end
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL midstart_strobe got=%0d exp=%0d", strobe_cnt, s0); end
  endtask

  task automatic test_reset_mid();
    int s0;
    logic ack;
    logic [7:0] partial;
    do_reset();
    bus_start(); send_byte(8'hC0, ack); send_byte(8'h77, ack);
    partial = 8'h5A;
    send_bits(partial, 4);
    dio_m = partial[4]; cyc(Q);
    bus_clk = 1'b1; cyc(Q);
    rst_n = 1'b0; cyc(3);
    checks++; if (seg_data !== 48'h0) begin failures++; $display("FAIL rstmid_seg got=%h exp=0", seg_data); end
    checks++; if (proto_err !== 1'b0 || tm1637_dio_oe !== 1'b0) begin failures++; $display("FAIL rstmid_err_oe got=%b/%b exp=0/0", proto_err, tm1637_dio_oe); end
    checks++; if (debug_state !== 3'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", debug_state); end
    rst_n = 1'b1;
    bus_clk = 1'b1; dio_m = 1'b1; cyc(H);
    s0 = strobe_cnt;
    bus_start(); send_byte(8'hC0, ack); send_byte(8'h12, ack); bus_stop();
    checks++; if (seg_data !== 48'h00_00_00_00_00_12) begin failures++; $display("FAIL rstmid_after_seg got=%h exp=%h", seg_data, 48'h12); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rstmid_after_err got=%b exp=0", proto_err); end
    checks++; if (strobe_cnt !== s0 + 1) begin failures++; $display("FAIL rstmid_after_strobe got=%0d exp=%0d", strobe_cnt, s0 + 1); end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_display_ctrl();
    test_fixed_addr();
    test_auto_wrap();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1637_responder.md
TM1637_RESPONDER -- requirements
Module: tm1637_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: input synchronizer depth on tm1637_clk and tm1637_dio_in; legal values 2..3.
REQ-002 Parameter NUM_DIGITS, default 6: number of display RAM bytes; legal values 1..6.
REQ-003 clk_50M  input  1: single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1: reset, synchronous and active-low.
REQ-005 tm1637_clk  input  1: bus clock from the TM1637 driver, asynchronous to clk_50M.
REQ-006 tm1637_dio_in  input  1: bus data line as sensed, asynchronous.
REQ-007 tm1637_dio_oe  output  1: 1 = pull DIO low (ACK); 0 = release.
REQ-008 seg_data  output  8*NUM_DIGITS: display RAM; digit n occupies bits [8n+7:8n].
REQ-009 disp_on  output  1: display-on bit from the last display-control command.
REQ-010 brightness  output  3: pulse-width code from the last display-control command.
REQ-011 update_strobe  output  1: one-cycle pulse at STOP when the transaction changed any register.
REQ-012 proto_err  output  1: sticky; set on any protocol error; cleared only by reset.
REQ-013 debug_state  output  3: current FSM state encoding.

Function
REQ-014 Synchronize CLK and DIO through SYNC_STAGES flops; all edge and level decisions use the synchronized values.
REQ-015 START = DIO falling while CLK high. STOP = DIO rising while CLK high. Both are recognized in every state.
REQ-016 FSM states:
- IDLE
- START: wait for CLK low
- BIT: sample DIO on each CLK rising edge, LSB first, 3-bit counter 0..7
- ACK
- HOLD: wait for STOP or repeated START
REQ-017 After the 8th CLK falling edge: enter ACK and assert tm1637_dio_oe. Deassert it on the 9th CLK falling edge; the latency from the synchronized edge is 1 cycle.
REQ-018 On leaving ACK, return to BIT with counter 0. The byte completes at the 8th rising-edge sample.
REQ-019 The first byte after START is the command. bits[7:6] select:
- 01: data command. bit2=1 fixed address, bit2=0 auto-increment; latched into the internal mode flag.
- 11: address command. addr = bits[2:0].
- 10: display control. disp_on = bit3, brightness = bits[2:0].
- 00: proto_err.
REQ-020 Data command with bit1=1 (key read) is unsupported: set proto_err, give no ACK, go to HOLD.
REQ-021 Each byte after an address command writes seg_data digit[addr]. In auto mode, addr then increments and wraps from NUM_DIGITS-1 to 0.
REQ-022 Address command with addr >= NUM_DIGITS: set proto_err, still ACK, discard following data bytes.
REQ-023 Bytes following a data-command or display-control byte within the same transaction: set proto_err and ignore.
REQ-024 STOP in any state returns to IDLE with tm1637_dio_oe=0. update_strobe fires one cycle after STOP only if a write or control update occurred.
REQ-025 START during BIT, ACK or HOLD aborts the partial byte (no write) and sets proto_err only if the bit counter is nonzero.
REQ-026 A simultaneous CLK and DIO change in the same synchronized cycle is treated as a CLK edge only.

Reset
REQ-027 With rst_n low at a clock edge, the following values hold from the next cycle:
- state IDLE
- tm1637_dio_oe 0
- seg_data 0
- disp_on 0
- brightness 0
- update_strobe 0
- proto_err 0
- mode auto-increment
- addr 0
- synchronizers set to 1 (idle bus)
REQ-028 Reset mid-transaction discards all partial state. The first post-reset bus activity is decoded only from a fresh START.

Structure
REQ-029 Shared package tm1637_pkg holds:
- FSM state enum
- command class codes (2'b01, 2'b11, 2'b10)
- bit positions for fixed-address, key-read and display-on
- DIO/CLK idle level constants
REQ-030 One sub-module, tm1637_sync_edge: SYNC_STAGES synchronizer plus registered rise/fall detect, instantiated once for CLK and once for DIO.

Verification
REQ-031 START, 0x40, STOP; START, 0xC0, 0x3F, 0x06, 0x5B, STOP -> seg_data[23:0]=0x5B063F, four ACK pulses in the second transaction, one update_strobe per STOP.
REQ-032 START, 0x8F, STOP -> disp_on=1, brightness=7, one update_strobe; seg_data unchanged.
REQ-033 START, 0x44, STOP; START, 0xC5, 0x11, 0x22, STOP -> digit5=0x22 (fixed address); digits 0..4 unchanged.
REQ-034 Auto mode, START, 0xC4, four bytes 0xA1..0xA4 -> digit4=A1, digit5=A2, digit0=A3, digit1=A4 (wrap).
REQ-035 Error cases -> proto_err=1, no register change:
- START, 0x42 (key read) -> no ACK
- START, 0x00
- START mid-byte after 3 bits
REQ-036 Assert rst_n=0 during the 5th bit of a data byte, then release -> all outputs at reset values; a following valid transaction decodes correctly.
